// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the round-robin write arbiter: FSM state encoding and default sizes.
package reg_write_arbiter_pkg;

  localparam int unsigned DefaultNReq  = 4;
  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StWrite = 2'd2
  } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter.
import reg_write_arbiter_pkg::*;

interface reg_write_arbiter_if #(
  parameter int unsigned N_REQ = DefaultNReq,
  parameter int unsigned WIDTH = DefaultWidth
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   busy;

  modport master (output req, wdata, input gnt, ack, q, busy);
  modport slave  (input req, wdata, output gnt, ack, q, busy);
endinterface

// File: rtl/reg_write_arbiter_pick.sv
// Combinational round-robin pick: first set bit of req_masked_i searching from last_i+1 upward.
import reg_write_arbiter_pkg::*;

module rr_priority_pick #(
  parameter int unsigned N_REQ = DefaultNReq,
  parameter int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_masked_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(last_i) + k) % N_REQ;
      cand_idx = IdxW'(cand);
      if (!any_o && req_masked_i[cand_idx]) begin
        any_o              = 1'b1;
        idx_o              = cand_idx;
        onehot_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register written by N_REQ requesters.
import reg_write_arbiter_pkg::*;

module reg_write_arbiter #(
  parameter int unsigned N_REQ = DefaultNReq,
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic                clk,
  input logic                reset,
  reg_write_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [IdxW-1:0]  gidx_q, gidx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic [N_REQ-1:0] last_oh;
  logic [N_REQ-1:0] pick_in;
  logic [N_REQ-1:0] pick_oh;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_any;

  assign last_oh = {{(N_REQ-1){1'b0}}, 1'b1} << last_q;
  // Just-acked requester sits out the WRITE-cycle arbitration so others get a turn.
  assign pick_in = (state_q == StWrite) ? (bus.req & ~last_oh) : bus.req;

  rr_priority_pick #(
    .N_REQ(N_REQ),
    .IdxW (IdxW)
  ) u_pick (
    .req_masked_i(pick_in),
    .last_i      (last_q),
    .onehot_o    (pick_oh),
    .idx_o       (pick_idx),
    .any_o       (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_any) state_d = StGrant;
      StGrant: state_d = bus.req[gidx_q] ? StWrite : StIdle;
      StWrite: state_d = pick_any ? StGrant : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    ack_d  = '0;
    q_d    = q_q;
    last_d = last_q;
    gidx_d = gidx_q;
    unique case (state_q)
      StIdle, StWrite: begin
        if (pick_any) begin
          gnt_d  = pick_oh;
          gidx_d = pick_idx;
        end
      end
      StGrant: begin
        // A withdrawn request aborts without touching q or the pointer.
        if (bus.req[gidx_q]) begin
          q_d    = bus.wdata[gidx_q*WIDTH +: WIDTH];
          ack_d  = gnt_q;
          last_d = gidx_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IdxW'(N_REQ - 1);
      gidx_q <= '0;
      gnt_q  <= '0;
      ack_q  <= '0;
      q_q    <= '0;
    end else begin
      last_q <= last_d;
      gidx_q <= gidx_d;
      gnt_q  <= gnt_d;
      ack_q  <= ack_d;
      q_q    <= q_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.q    = q_q;
  assign bus.busy = (state_q != StIdle);

endmodule
